// File: rtl/i2s_tdm_rx.sv
// I2S/TDM serial audio receiver: oversampled pins, frame lock, show-ahead sample FIFO.
// Optional I2S_RX_FRAME_CNT_EN adds out_frame, a 16-bit frame index stored with each sample.
module i2s_tdm_rx #(
  parameter int SAMPLE_WIDTH = 24,
  parameter int SLOT_WIDTH   = 32,
  parameter int NUM_SLOTS    = 8,
  parameter int FIFO_DEPTH   = 4,
  parameter int SYNC_STAGES  = 2,
  localparam int CHAN_W      = (NUM_SLOTS > 2) ? $clog2(NUM_SLOTS) : 1
) (
  input  logic                    sys_clk,
  input  logic                    sys_rst_n,
  input  logic                    en,
  input  logic                    i2s_bclk,
  input  logic                    i2s_lrclk,
  input  logic                    i2s_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [SAMPLE_WIDTH-1:0] out_data,
  output logic [CHAN_W-1:0]       out_chan,
`ifdef I2S_RX_FRAME_CNT_EN
  output logic [15:0]             out_frame,
`endif
  output logic                    locked,
  output logic                    overflow,
  output logic                    frame_err,
  input  logic                    clear_err
);
  localparam int BIT_W  = (SLOT_WIDTH > 2) ? $clog2(SLOT_WIDTH) : 1;
  localparam int ADDR_W = (FIFO_DEPTH > 2) ? $clog2(FIFO_DEPTH) : 1;
`ifdef I2S_RX_FRAME_CNT_EN
  localparam int TAG_W  = 16;
`else
  localparam int TAG_W  = 0;
`endif
  localparam int ENTRY_W = TAG_W + CHAN_W + SAMPLE_WIDTH;
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(SLOT_WIDTH - 1);
  localparam logic [CHAN_W-1:0] SLOT_LAST = CHAN_W'(NUM_SLOTS - 1);
  localparam logic [ADDR_W:0]   FIFO_FULL = (ADDR_W + 1)'(FIFO_DEPTH);

  // All three pins travel through the same chain so data and lrclk stay aligned with bclk.
  logic [2:0] sync_reg [SYNC_STAGES];
  logic       bclk_s, lr_s, data_s;

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_reg[i] <= '0;
    end else begin
      sync_reg[0] <= {i2s_bclk, i2s_lrclk, i2s_data};
      for (int i = 1; i < SYNC_STAGES; i++) sync_reg[i] <= sync_reg[i-1];
    end
  end

  assign {bclk_s, lr_s, data_s} = sync_reg[SYNC_STAGES-1];

  typedef enum logic {UNLOCKED, LOCKED} state_t;

  state_t                  state_reg;
  logic                    bclk_prev_reg;
  logic                    lr_prev_reg;
  logic [BIT_W-1:0]        bit_cnt_reg;
  logic [CHAN_W-1:0]       slot_cnt_reg;
  logic [SAMPLE_WIDTH-1:0] shift_reg;
  logic                    push_reg;
  logic [ENTRY_W-1:0]      push_data_reg;

  logic                    bit_event, fs, frame_end, err_set, take_bit;
  logic [SAMPLE_WIDTH:0]   shift_ext;
  logic [SAMPLE_WIDTH-1:0] sample_next;
  logic [ENTRY_W-1:0]      entry_in;

  assign bit_event   = bclk_s & ~bclk_prev_reg;
  assign fs          = bit_event & ~lr_s & lr_prev_reg;
  assign frame_end   = (bit_cnt_reg == BIT_LAST) && (slot_cnt_reg == SLOT_LAST);
  assign err_set     = en && bit_event && (state_reg == LOCKED) && (fs != frame_end);
  assign take_bit    = 32'(bit_cnt_reg) < SAMPLE_WIDTH;
  assign shift_ext   = {shift_reg, data_s};
  assign sample_next = take_bit ? shift_ext[SAMPLE_WIDTH-1:0] : shift_reg;
  assign locked      = (state_reg == LOCKED);

`ifdef I2S_RX_FRAME_CNT_EN
  logic [15:0] frame_cnt_reg;

  // Counts frame starts seen while locked; the slot closed by an FS keeps the old index.
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) frame_cnt_reg <= '0;
    else if (en && fs && state_reg == LOCKED) frame_cnt_reg <= frame_cnt_reg + 16'd1;
  end

  assign entry_in = {frame_cnt_reg, slot_cnt_reg, sample_next};
`else
  assign entry_in = {slot_cnt_reg, sample_next};
`endif

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      state_reg     <= UNLOCKED;
      bclk_prev_reg <= 1'b0;
      lr_prev_reg   <= 1'b0;
      bit_cnt_reg   <= '0;
      slot_cnt_reg  <= '0;
      shift_reg     <= '0;
      push_reg      <= 1'b0;
      push_data_reg <= '0;
    end else begin
      bclk_prev_reg <= bclk_s;
      push_reg      <= 1'b0;
      if (bit_event) lr_prev_reg <= lr_s;
      if (!en) begin
        state_reg    <= UNLOCKED;
        bit_cnt_reg  <= '0;
        slot_cnt_reg <= '0;
      end else if (bit_event) begin
        if (state_reg == UNLOCKED) begin
          // The FS bit belongs to the previous frame, so it is dropped.
          if (fs) begin
            state_reg    <= LOCKED;
            bit_cnt_reg  <= '0;
            slot_cnt_reg <= '0;
          end
        end else if (fs && !frame_end) begin
          bit_cnt_reg  <= '0;
          slot_cnt_reg <= '0;
        end else begin
          shift_reg <= sample_next;
          if (bit_cnt_reg == BIT_LAST) begin
            push_reg      <= 1'b1;
            push_data_reg <= entry_in;
          end
          if (frame_end) begin
            bit_cnt_reg  <= '0;
            slot_cnt_reg <= '0;
            if (!fs) state_reg <= UNLOCKED;
          end else if (bit_cnt_reg == BIT_LAST) begin
            bit_cnt_reg  <= '0;
            slot_cnt_reg <= slot_cnt_reg + CHAN_W'(1);
          end else begin
            bit_cnt_reg <= bit_cnt_reg + BIT_W'(1);
          end
        end
      end
    end
  end

  logic [ENTRY_W-1:0] mem [FIFO_DEPTH];
  logic [ADDR_W-1:0]  wr_ptr_reg, rd_ptr_reg, rd_ptr_next;
  logic [ADDR_W:0]    count_reg, count_next;
  logic [ENTRY_W-1:0] head_reg, head_next;
  logic               overflow_reg, frame_err_reg;
  logic               pop, full, push_ok;

  assign out_valid   = (count_reg != '0);
  assign pop         = out_valid & out_ready;
  assign full        = (count_reg == FIFO_FULL);
  assign push_ok     = push_reg & (~full | pop);
  assign rd_ptr_next = rd_ptr_reg + ADDR_W'(pop);
  assign count_next  = count_reg + (ADDR_W + 1)'(push_ok) - (ADDR_W + 1)'(pop);
  // The head register bypasses the array when the new head is being written this cycle.
  assign head_next   = (push_ok && rd_ptr_next == wr_ptr_reg) ? push_data_reg : mem[rd_ptr_next];

  always_ff @(posedge sys_clk) begin
    if (push_ok) mem[wr_ptr_reg] <= push_data_reg;
  end

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      count_reg     <= '0;
      head_reg      <= '0;
      overflow_reg  <= 1'b0;
      frame_err_reg <= 1'b0;
    end else begin
      if (push_ok) wr_ptr_reg <= wr_ptr_reg + ADDR_W'(1);
      rd_ptr_reg <= rd_ptr_next;
      count_reg  <= count_next;
      if (count_next != '0) head_reg <= head_next;
      overflow_reg  <= (push_reg & full & ~pop) | (overflow_reg & ~clear_err);
      frame_err_reg <= err_set | (frame_err_reg & ~clear_err);
    end
  end

  assign out_data  = head_reg[SAMPLE_WIDTH-1:0];
  assign out_chan  = head_reg[SAMPLE_WIDTH +: CHAN_W];
  assign overflow  = overflow_reg;
  assign frame_err = frame_err_reg;
`ifdef I2S_RX_FRAME_CNT_EN
  assign out_frame = head_reg[ENTRY_W-1 -: 16];
`endif

endmodule

// File: tb/tb_i2s_tdm_rx.sv
// Directed bench for i2s_tdm_rx: a stereo (2-slot) and a TDM (8-slot) receiver share the pins.
module tb_i2s_tdm_rx;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, en2, en8, bclk, lrclk, data, rdy2, rdy8, clr;
  logic        v2, v8, lk2, lk8, ov2, ov8, fe2, fe8;
  logic [23:0] d2, d8;
  logic [0:0]  c2;
  logic [2:0]  c8;
`ifdef I2S_RX_FRAME_CNT_EN
  logic [15:0] f2, f8;
`endif

  i2s_tdm_rx #(.SAMPLE_WIDTH(24), .SLOT_WIDTH(32), .NUM_SLOTS(2), .FIFO_DEPTH(4), .SYNC_STAGES(2)) dut2 (
    .sys_clk(clk), .sys_rst_n(rst_n), .en(en2), .i2s_bclk(bclk), .i2s_lrclk(lrclk), .i2s_data(data),
    .out_valid(v2), .out_ready(rdy2), .out_data(d2), .out_chan(c2),
`ifdef I2S_RX_FRAME_CNT_EN
    .out_frame(f2),
`endif
    .locked(lk2), .overflow(ov2), .frame_err(fe2), .clear_err(clr));

  i2s_tdm_rx #(.SAMPLE_WIDTH(24), .SLOT_WIDTH(32), .NUM_SLOTS(8), .FIFO_DEPTH(4), .SYNC_STAGES(2)) dut8 (
    .sys_clk(clk), .sys_rst_n(rst_n), .en(en8), .i2s_bclk(bclk), .i2s_lrclk(lrclk), .i2s_data(data),
    .out_valid(v8), .out_ready(rdy8), .out_data(d8), .out_chan(c8),
`ifdef I2S_RX_FRAME_CNT_EN
    .out_frame(f8),
`endif
    .locked(lk8), .overflow(ov8), .frame_err(fe8), .clear_err(clr));

  typedef struct packed {
    logic [31:0] ch;
    logic [31:0] dat;
  } samp_t;

  typedef struct {
    logic [23:0] left_in;
    logic [23:0] right_in;
    logic [31:0] exp_ch0;
    logic [31:0] exp_d0;
    logic [31:0] exp_ch1;
    logic [31:0] exp_d1;
  } vec_t;

  int          total = 0;
  int          bad = 0;
  logic [23:0] slot_val [8];
  logic        lr_stuck = 1'b0;
  samp_t       q2 [$];
  samp_t       q8 [$];
  vec_t        vecs [4];

  // Capture every accepted sample, sampled 2 time units after the falling edge.
  initial forever begin
    @(negedge clk);
    #2;
    if (v2 && rdy2) q2.push_back({32'(c2), 32'(d2)});
    if (v8 && rdy8) q8.push_back({32'(c8), 32'(d8)});
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end else begin
      $display("ok   %s: %0h", name, act);
    end
  endtask

  task automatic expect_samp(input int which, input string name, input logic [31:0] ch, input logic [31:0] dat);
    samp_t s;
    int    n;
    total++;
    n = (which == 2) ? q2.size() : q8.size();
    if (n == 0) begin
      bad++;
      $display("FAIL %s: got no sample want chan %0d data %0h", name, ch, dat);
    end else begin
      if (which == 2) s = q2.pop_front();
      else s = q8.pop_front();
      if (s.ch !== ch || s.dat !== dat) begin
        bad++;
        $display("FAIL %s: got chan %0d data %0h want chan %0d data %0h", name, s.ch, s.dat, ch, dat);
      end else begin
        $display("ok   %s: chan %0d data %0h", name, s.ch, s.dat);
      end
    end
  endtask

  // Standard I2S timing: lrclk drops one bit before the MSB of slot 0 (50% duty frame sync).
  function automatic logic bit_lr(input int nsl, input int k);
    int fb;
    fb = nsl * 32;
    if (lr_stuck) return 1'b0;
    return ((k + 1) % fb) >= (fb / 2);
  endfunction

  function automatic logic bit_d(input int k);
    logic [31:0] w;
    w = {slot_val[k / 32], 8'h5A};
    return w[31 - (k % 32)];
  endfunction

  task automatic send_bit(input logic lr, input logic d);
    bclk = 1'b0; lrclk = lr; data = d;
    cyc(4);
    bclk = 1'b1;
    cyc(4);
  endtask

  task automatic send_range(input int nsl, input int k0, input int k1);
    for (int k = k0; k <= k1; k++) send_bit(bit_lr(nsl, k), bit_d(k));
  endtask

  task automatic send_frame(input int nsl);
    send_range(nsl, 0, nsl * 32 - 1);
  endtask

  task automatic pulse_clear();
    clr = 1'b1;
    cyc(1);
    clr = 1'b0;
    cyc(1);
  endtask

  initial begin
    vecs[0] = '{24'hA5A5A5, 24'h123456, 0, 32'hA5A5A5, 1, 32'h123456};
    vecs[1] = '{24'hFFFFFF, 24'h000000, 0, 32'hFFFFFF, 1, 32'h000000};
    vecs[2] = '{24'h800001, 24'h7FFFFE, 0, 32'h800001, 1, 32'h7FFFFE};
    vecs[3] = '{24'h000001, 24'hC3C3C3, 0, 32'h000001, 1, 32'hC3C3C3};

    rst_n = 1'b0; en2 = 1'b0; en8 = 1'b0; rdy2 = 1'b1; rdy8 = 1'b1; clr = 1'b0;
    bclk = 1'b0; lrclk = 1'b0; data = 1'b0;
    cyc(3);
    rst_n = 1'b1;
    cyc(1);
    check("rst_valid", 32'(v2), 0);
    check("rst_locked", 32'(lk2), 0);
    check("rst_overflow", 32'(ov2), 0);
    check("rst_frame_err", 32'(fe2), 0);
    check("rst_data", 32'(d2), 0);
    check("rst_chan", 32'(c2), 0);

    // Lock: the first frame ends in an FS and yields no samples.
    en2 = 1'b1;
    slot_val[0] = 24'h0F1E2D; slot_val[1] = 24'h3C4B5A;
    send_frame(2);
    cyc(6);
    check("lock_locked", 32'(lk2), 1);
    check("lock_no_samples", 32'(q2.size()), 0);

    // Latency from the last bclk rise of slot 0 to out_valid.
    slot_val[0] = 24'hA5A5A5; slot_val[1] = 24'h123456;
    send_range(2, 0, 30);
    bclk = 1'b0; lrclk = bit_lr(2, 31); data = bit_d(31);
    cyc(4);
    bclk = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      cyc(1);
      if (i < 4) check($sformatf("lat_wait%0d", i), 32'(v2), 0);
      else begin
        check("lat_valid", 32'(v2), 1);
        check("lat_data", 32'(d2), 32'hA5A5A5);
      end
    end
    send_range(2, 32, 63);
    cyc(6);
    expect_samp(2, "lat_left", 0, 32'hA5A5A5);
    expect_samp(2, "lat_right", 1, 32'h123456);

    for (int i = 0; i < 4; i++) begin
      slot_val[0] = vecs[i].left_in; slot_val[1] = vecs[i].right_in;
      send_frame(2);
      cyc(6);
      expect_samp(2, $sformatf("vec%0d_left", i), vecs[i].exp_ch0, vecs[i].exp_d0);
      expect_samp(2, $sformatf("vec%0d_right", i), vecs[i].exp_ch1, vecs[i].exp_d1);
    end
    check("stereo_frame_err", 32'(fe2), 0);
    check("stereo_locked", 32'(lk2), 1);

    // Eight-slot TDM on the second receiver.
    en2 = 1'b0; en8 = 1'b1;
    for (int s = 0; s < 8; s++) slot_val[s] = 24'h100000 + 24'(s);
    send_frame(8);
    cyc(6);
    check("tdm_locked", 32'(lk8), 1);
    send_frame(8);
    cyc(6);
    for (int s = 0; s < 8; s++) expect_samp(8, $sformatf("tdm_slot%0d", s), 32'(s), 32'h100000 + 32'(s));
    check("tdm_frame_err", 32'(fe8), 0);
    check("stereo_disabled_unlocked", 32'(lk2), 0);

    // Overflow: six slots into a four-entry FIFO with no consumer.
    en8 = 1'b0; en2 = 1'b1; rdy2 = 1'b0;
    send_frame(2);
    slot_val[0] = 24'h111111; slot_val[1] = 24'h222222; send_frame(2);
    slot_val[0] = 24'h333333; slot_val[1] = 24'h444444; send_frame(2);
    slot_val[0] = 24'h555555; slot_val[1] = 24'h666666; send_frame(2);
    cyc(6);
    check("ovf_set", 32'(ov2), 1);
    check("ovf_head", 32'(d2), 32'h111111);
    rdy2 = 1'b1;
    cyc(10);
    expect_samp(2, "ovf_drain0", 0, 32'h111111);
    expect_samp(2, "ovf_drain1", 1, 32'h222222);
    expect_samp(2, "ovf_drain2", 0, 32'h333333);
    expect_samp(2, "ovf_drain3", 1, 32'h444444);
    check("ovf_no_extra", 32'(q2.size()), 0);
    check("ovf_empty", 32'(v2), 0);
    check("ovf_still_set", 32'(ov2), 1);
    pulse_clear();
    check("ovf_cleared", 32'(ov2), 0);

    // Early frame start injected at fcnt=40.
    slot_val[0] = 24'hABCDEF; slot_val[1] = 24'h654321;
    send_range(2, 0, 39);
    send_bit(1'b0, bit_d(40));
    cyc(6);
    check("inj_frame_err", 32'(fe2), 1);
    check("inj_locked", 32'(lk2), 1);
    expect_samp(2, "inj_slot0", 0, 32'hABCDEF);
    check("inj_no_partial", 32'(q2.size()), 0);
    slot_val[0] = 24'h0F0F0F; slot_val[1] = 24'hF0F0F0;
    send_frame(2);
    cyc(6);
    expect_samp(2, "inj_next_left", 0, 32'h0F0F0F);
    expect_samp(2, "inj_next_right", 1, 32'hF0F0F0);
    pulse_clear();
    check("inj_cleared", 32'(fe2), 0);

    // lrclk stuck low for a whole frame.
    slot_val[0] = 24'h112233; slot_val[1] = 24'h445566;
    lr_stuck = 1'b1;
    send_frame(2);
    lr_stuck = 1'b0;
    cyc(6);
    check("stuck_frame_err", 32'(fe2), 1);
    check("stuck_unlocked", 32'(lk2), 0);
    expect_samp(2, "stuck_left", 0, 32'h112233);
    expect_samp(2, "stuck_right", 1, 32'h445566);
    pulse_clear();
    check("stuck_cleared", 32'(fe2), 0);
    slot_val[0] = 24'h778899; slot_val[1] = 24'hAABBCC;
    send_frame(2);
    cyc(6);
    check("stuck_relocked", 32'(lk2), 1);
    check("stuck_relock_quiet", 32'(q2.size()), 0);
    send_frame(2);
    cyc(6);
    expect_samp(2, "resume_left", 0, 32'h778899);
    expect_samp(2, "resume_right", 1, 32'hAABBCC);

    // Reset mid-slot with two samples queued.
    rdy2 = 1'b0;
    slot_val[0] = 24'h135790; slot_val[1] = 24'h246802;
    send_frame(2);
    cyc(6);
    check("pre_rst_valid", 32'(v2), 1);
    send_range(2, 0, 10);
    rst_n = 1'b0;
    cyc(1);
    check("mid_rst_valid", 32'(v2), 0);
    check("mid_rst_locked", 32'(lk2), 0);
    check("mid_rst_data", 32'(d2), 0);
    rst_n = 1'b1;
    rdy2 = 1'b1;
    cyc(4);
    check("post_rst_empty", 32'(q2.size()), 0);
    send_range(2, 11, 63);
    cyc(6);
    check("post_rst_relock", 32'(lk2), 1);
    check("post_rst_quiet", 32'(q2.size()), 0);
    slot_val[0] = 24'hDEAD01; slot_val[1] = 24'hBEEF02;
    send_frame(2);
    cyc(6);
    expect_samp(2, "post_rst_left", 0, 32'hDEAD01);
    expect_samp(2, "post_rst_right", 1, 32'hBEEF02);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
